// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types, constants and helpers for the 5-stage pipeline.
//            - fetch_state_t : fetch FSM states (IDLE, REQ, DISCARD)
//            - NOP_INSTR     : instruction word used for pipeline bubbles
//            - OPCODE/FUNCT field bit positions
//            - jump_target() : J-type target from PC+4 and instruction
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam int          FUNCT_MSB  = 5;
    localparam int          FUNCT_LSB  = 0;

    // Region bits come from PC+4, the 26-bit index is a word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                                input logic [31:0] instr);
        return {pcplus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register. Flush beats stall; when nothing is
//            loaded the register fills with a bubble (NOP, PC+4 = 0, invalid).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_flush         - load a bubble
//            i_stall         - hold current contents
//            i_load          - capture i_instr / i_pcplus4 as a valid entry
//            i_instr         - instruction from memory
//            i_pcplus4       - PC+4 of that instruction
//            o_instr         - instruction in decode
//            o_pcplus4       - PC+4 in decode
//            o_valid         - entry is a real instruction
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            o_instr   <= NOP_INSTR;
            o_pcplus4 <= 32'h0;
            o_valid   <= 1'b0;
        end else if (i_stall) begin
            // hold
        end else if (i_load) begin
            o_instr   <= i_instr;
            o_pcplus4 <= i_pcplus4;
            o_valid   <= 1'b1;
        end else begin
            o_instr   <= NOP_INSTR;
            o_pcplus4 <= 32'h0;
            o_valid   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage with IF/ID register. Owns the PC, talks
//            to instruction memory over a ready handshake and applies
//            branch/jump redirects resolved in decode.
// Config   : IF_IMEM_WAIT_EN - when defined, IMReady is honoured and a
//            redirect during an outstanding request drains the wrong-path
//            response (DISCARD). When undefined memory is assumed to answer
//            every cycle and FetchBusy is tied low.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            StallF / StallD        - hold PC / hold IF/ID
//            FlushD                 - bubble into IF/ID
//            PCSrcD, PCBranchD      - taken branch and its target
//            JumpD                  - jump in decode
//            IMAddr, IMReq          - memory request (registered)
//            IMRdata, IMReady       - memory response
//            InstrD, OpcodeD,
//            FunctD, PCPlus4D,
//            ValidD                 - decode-side view of IF/ID
//            FetchBusy              - request outstanding, not ready
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    output logic [31:0] IMAddr,
    output logic        IMReq,
    input  logic [31:0] IMRdata,
    input  logic        IMReady,
    output logic [31:0] InstrD,
    output logic [5:0]  OpcodeD,
    output logic [5:0]  FunctD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    fetch_state_t r_state;
    logic [31:0]  r_pcf;
    logic         r_imreq;

    logic         w_ready;
    logic         w_redirect;
    logic         w_deliver;
    logic [31:0]  w_target;
    logic [31:0]  w_pcplus4f;

`ifdef IF_IMEM_WAIT_EN
    logic [31:0]  r_redir_pc;

    assign w_ready   = IMReady;
    assign FetchBusy = r_imreq & ~IMReady;
`else
    logic         w_unused_imready;

    assign w_unused_imready = IMReady;
    assign w_ready          = 1'b1;
    assign FetchBusy        = 1'b0;
`endif

    // A stalled fetch stage ignores redirects entirely.
    assign w_redirect = (JumpD | PCSrcD) & ~StallF;
    assign w_target   = JumpD ? jump_target(PCPlus4D, InstrD) : PCBranchD;
    assign w_pcplus4f = r_pcf + 32'd4;

    // Only a response to a right-path request reaches decode.
    assign w_deliver  = (r_state == REQ) & w_ready & ~w_redirect;

    // The PC register doubles as the request address: it only changes when
    // the current request completes, which keeps IMAddr stable while waiting.
    assign IMAddr = r_pcf;
    assign IMReq  = r_imreq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pcf      <= RESET_PC;
            r_imreq    <= 1'b0;
`ifdef IF_IMEM_WAIT_EN
            r_redir_pc <= 32'h0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_imreq <= 1'b1;
                end
                REQ: begin
                    if (w_ready) begin
                        if (w_redirect) begin
                            r_pcf <= w_target;
                        end else if (!StallF) begin
                            r_pcf <= w_pcplus4f;
                        end
                    end
`ifdef IF_IMEM_WAIT_EN
                    else if (w_redirect) begin
                        // Memory still owes us the old-path word; park the
                        // target until it arrives.
                        r_redir_pc <= w_target;
                        r_state    <= DISCARD;
                    end
`endif
                end
`ifdef IF_IMEM_WAIT_EN
                DISCARD: begin
                    if (w_ready) begin
                        // A redirect arriving with the response is the newest.
                        r_pcf   <= w_redirect ? w_target : r_redir_pc;
                        r_state <= REQ;
                    end else if (w_redirect) begin
                        r_redir_pc <= w_target;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_imreq <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (FlushD),
        .i_stall   (StallD),
        .i_load    (w_deliver),
        .i_instr   (IMRdata),
        .i_pcplus4 (w_pcplus4f),
        .o_instr   (InstrD),
        .o_pcplus4 (PCPlus4D),
        .o_valid   (ValidD)
    );

    assign OpcodeD = InstrD[OPCODE_MSB:OPCODE_LSB];
    assign FunctD  = InstrD[FUNCT_MSB:FUNCT_LSB];

endmodule
`default_nettype wire
